// File: rtl/conv3x3_stream_filter_if.sv
// Pixel stream bundle for the 3x3 blur: raw RGB in with sync qualifiers,
// filtered pixel out with the coordinates of the input pixel that produced it.
interface conv3x3_stream_filter_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] input_img;
  logic              HSYNC;
  logic              VSYNC;
  logic [DATA_W-1:0] pixel_out;
  logic [8:0]        row_out;
  logic [9:0]        col_out;
  logic              valid_out;

  modport master (
    output input_img, HSYNC, VSYNC,
    input  pixel_out, row_out, col_out, valid_out
  );

  modport slave (
    input  input_img, HSYNC, VSYNC,
    output pixel_out, row_out, col_out, valid_out
  );
endinterface

// File: rtl/conv3x3_stream_filter.sv
// Streaming 3x3 Gaussian blur (1 2 1 / 2 4 2 / 1 2 1, >>4) over 24-bit RGB video.
// Three rotating line RAMs feed a zero-padded window; fixed 3-cycle latency.
module conv3x3_stream_filter #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = 24
) (
  input  logic                        clk,
  input  logic                        resetn,
  conv3x3_stream_filter_if.slave      bus
);
  localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
  localparam logic [8:0] ROW_LAST = 9'(IMG_H - 1);

  logic              w_acc;
  logic [9:0]        r_col;
  logic [8:0]        r_row;
  logic [1:0]        r_bank;

  logic [DATA_W-1:0] r_mem [3][IMG_W];
  logic [DATA_W-1:0] r_rd  [3];

  logic              r_s1_vld;
  logic [DATA_W-1:0] r_s1_pix;
  logic [8:0]        r_s1_row;
  logic [9:0]        r_s1_col;
  logic [1:0]        r_s1_bank;
  logic [1:0]        w_b1;
  logic [1:0]        w_b2;
  logic [DATA_W-1:0] w_up1;
  logic [DATA_W-1:0] w_up2;

  logic [DATA_W-1:0] r_win [3][3];
  logic              r_s2_vld;
  logic [8:0]        r_s2_row;
  logic [9:0]        r_s2_col;

  logic [11:0]       w_sum [3];
  logic [11:0]       r_sum [3];
  logic              r_s3_vld;
  logic [8:0]        r_s3_row;
  logic [9:0]        r_s3_col;

  assign w_acc = bus.HSYNC & bus.VSYNC;

  // r_bank tracks row mod 3; forced to 0 at frame wrap so IMG_H need not be a multiple of 3
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col  <= '0;
      r_row  <= '0;
      r_bank <= '0;
    end else if (w_acc) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        if (r_row == ROW_LAST) begin
          r_row  <= '0;
          r_bank <= '0;
        end else begin
          r_row  <= r_row + 9'd1;
          r_bank <= (r_bank == 2'd2) ? 2'd0 : r_bank + 2'd1;
        end
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_bank == 2'(i)) begin
          r_mem[i][r_col] <= bus.input_img;
          r_rd[i]         <= bus.input_img;
        end else begin
          r_rd[i]         <= r_mem[i][r_col];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_vld  <= 1'b0;
      r_s1_pix  <= '0;
      r_s1_row  <= '0;
      r_s1_col  <= '0;
      r_s1_bank <= '0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_pix  <= bus.input_img;
        r_s1_row  <= r_row;
        r_s1_col  <= r_col;
        r_s1_bank <= r_bank;
      end
    end
  end

  assign w_b1  = (r_s1_bank == 2'd0) ? 2'd2 : r_s1_bank - 2'd1;
  assign w_b2  = (r_s1_bank == 2'd2) ? 2'd0 : r_s1_bank + 2'd1;
  assign w_up1 = (r_s1_row >= 9'd1) ? r_rd[w_b1] : '0;
  assign w_up2 = (r_s1_row >= 9'd2) ? r_rd[w_b2] : '0;

  // Older columns are cleared at col 0/1 so the previous line's tail never enters the window
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          r_win[r][c] <= '0;
      r_s2_vld <= 1'b0;
      r_s2_row <= '0;
      r_s2_col <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        for (int unsigned r = 0; r < 3; r++) begin
          r_win[r][0] <= (r_s1_col < 10'd2) ? '0 : r_win[r][1];
          r_win[r][1] <= (r_s1_col == 10'd0) ? '0 : r_win[r][2];
        end
        r_win[0][2] <= w_up2;
        r_win[1][2] <= w_up1;
        r_win[2][2] <= r_s1_pix;
        r_s2_row    <= r_s1_row;
        r_s2_col    <= r_s1_col;
      end
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < 3; ch++) begin
      w_sum[ch] = '0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          w_sum[ch] = w_sum[ch] + (12'(r_win[r][c][8*ch +: 8])
                      << ((r == 1 ? 1 : 0) + (c == 1 ? 1 : 0)));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned ch = 0; ch < 3; ch++)
        r_sum[ch] <= '0;
      r_s3_vld <= 1'b0;
      r_s3_row <= '0;
      r_s3_col <= '0;
    end else begin
      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) begin
        for (int unsigned ch = 0; ch < 3; ch++)
          r_sum[ch] <= w_sum[ch];
        r_s3_row <= r_s2_row;
        r_s3_col <= r_s2_col;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.pixel_out <= '0;
      bus.row_out   <= '0;
      bus.col_out   <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      bus.valid_out <= r_s3_vld;
      if (r_s3_vld) begin
        bus.pixel_out <= {8'(r_sum[2] >> 4), 8'(r_sum[1] >> 4), 8'(r_sum[0] >> 4)};
        bus.row_out   <= r_s3_row;
        bus.col_out   <= r_s3_col;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_stream_filter.sv
// Scoreboard bench for conv3x3_stream_filter on a reduced 20x10 frame:
// a full-frame image model predicts every output, checked with exact latency.
module tb_conv3x3_stream_filter;
  localparam int W = 20;
  localparam int H = 10;

  typedef struct {
    logic [23:0] pix;
    int          row;
    int          col;
    int          acc;
    int          mode;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  conv3x3_stream_filter_if #(.DATA_W(24)) bus ();

  conv3x3_stream_filter #(.IMG_W(W), .IMG_H(H), .DATA_W(24)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  exp_t        q[$];
  exp_t        mon_e;
  logic [23:0] img [H][W];
  int          m_row = 0;
  int          m_col = 0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          run = 1'b0;
  logic [42:0] last_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_blur(input int r, input int c);
    logic [23:0] res;
    logic [23:0] px;
    int sum, rr, cc, wt;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = 0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++) begin
          rr = r - 2 + dr;
          cc = c - 2 + dc;
          px = 24'h0;
          if (rr >= 0 && cc >= 0) px = img[rr][cc];
          wt = (dr == 1 ? 2 : 1) * (dc == 1 ? 2 : 1);
          sum += wt * int'(px[8*ch +: 8]);
        end
      res[8*ch +: 8] = 8'(sum >> 4);
    end
    return res;
  endfunction

  function automatic logic [23:0] pick(input int mode, input int r, input int c);
    case (mode)
      1:       return 24'hFFFFFF;
      2:       return (r == 5 && c == 5) ? 24'h000010 : 24'h000000;
      4:       return (r == H-1 || c == W-1) ? 24'hFFFFFF : 24'h000000;
      5:       return 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic drive(input logic [23:0] p, input logic hs, input logic vs, input int mode);
    exp_t e;
    @(negedge clk);
    bus.input_img = p;
    bus.HSYNC     = hs;
    bus.VSYNC     = vs;
    if (hs && vs) begin
      img[m_row][m_col] = p;
      e.pix  = model_blur(m_row, m_col);
      e.row  = m_row;
      e.col  = m_col;
      e.acc  = cyc + 1;
      e.mode = mode;
      q.push_back(e);
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic drive_frame(input int mode);
    for (int i = 0; i < W*H; i++) begin
      if (mode == 3 && m_row == 3) drive(24'($urandom), 1'b0, 1'b1, mode);
      if (mode == 3 && m_row == 6 && m_col == 0)
        for (int k = 0; k < 3; k++) drive(24'($urandom), 1'b1, 1'b0, mode);
      drive(pick(mode, m_row, m_col), 1'b1, 1'b1, mode);
    end
  endtask

  task automatic do_reset(input int hold_cycles);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_pixel_out", bus.pixel_out, 0);
    check_eq("rst_row_out",   bus.row_out,   0);
    check_eq("rst_col_out",   bus.col_out,   0);
    check_eq("rst_valid_out", bus.valid_out, 0);
    q.delete();
    m_row    = 0;
    m_col    = 0;
    last_out = '0;
    bus.HSYNC = 1'b0;
    bus.VSYNC = 1'b0;
    for (int i = 0; i < hold_cycles; i++) @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (run && resetn) begin
      if (bus.valid_out) begin
        if (q.size() == 0) begin
          check_eq("spurious_valid", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check_eq("pixel_out", bus.pixel_out, mon_e.pix);
          check_eq("row_out",   bus.row_out,   mon_e.row);
          check_eq("col_out",   bus.col_out,   mon_e.col);
          check_eq("latency",   cyc - mon_e.acc, 3);
          case (mon_e.mode)
            1: begin
              if (mon_e.row == 0 && mon_e.col == 0) check_eq("uni_00", bus.pixel_out, 24'h0F0F0F);
              if (mon_e.row == 1 && mon_e.col == 1) check_eq("uni_11", bus.pixel_out, 24'h8F8F8F);
              if (mon_e.row >= 2 && mon_e.col >= 2) check_eq("uni_int", bus.pixel_out, 24'hFFFFFF);
            end
            2: begin
              if (mon_e.row == 5 && mon_e.col == 5) check_eq("imp_55", bus.pixel_out, 24'h000001);
              if (mon_e.row == 5 && mon_e.col == 6) check_eq("imp_56", bus.pixel_out, 24'h000002);
              if (mon_e.row == 6 && mon_e.col == 6) check_eq("imp_66", bus.pixel_out, 24'h000004);
              if (mon_e.row == 7 && mon_e.col == 7) check_eq("imp_77", bus.pixel_out, 24'h000001);
            end
            4: if (mon_e.row < H-1 && mon_e.col <= 1) check_eq("edge_leak", bus.pixel_out, 0);
            5: if (mon_e.row <= 1) check_eq("wrap_leak", bus.pixel_out, 0);
            default: ;
          endcase
        end
        last_out = {bus.pixel_out, bus.row_out, bus.col_out};
      end else begin
        check_eq("hold", {bus.pixel_out, bus.row_out, bus.col_out}, last_out);
        if (q.size() > 0 && cyc - q[0].acc >= 3) check_eq("late_valid", 0, 1);
      end
    end
  end

  initial begin
    bus.input_img = '0;
    bus.HSYNC     = 1'b0;
    bus.VSYNC     = 1'b0;
    do_reset(2);
    run = 1'b1;

    drive_frame(1);
    drive_frame(2);
    drive_frame(3);
    drive_frame(4);
    drive_frame(5);

    while (!(m_row == 6 && m_col == 12)) drive(24'($urandom), 1'b1, 1'b1, 6);
    do_reset(3);
    for (int i = 0; i < 3*W; i++) begin
      if (i % 7 == 3) drive(24'($urandom), 1'b1, 1'b0, 7);
      drive(24'($urandom), 1'b1, 1'b1, 7);
    end
    drive(24'h0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
